// File: rtl/cpu_pkg.sv
// Shared LEGv8 front-end types: widths, PC step, fetch FSM states and FIFO entry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

   localparam int INSTR_W = 32;
   localparam int ADDR_W  = 64;
   localparam logic [ADDR_W-1:0] PC_STEP = 64'd4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [ADDR_W-1:0]  addr;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small instruction buffer; head is read straight from storage.
// Latency: a push is visible at the head one cycle later.
// Backpressure: pushes into a full buffer without a pop are dropped; flush beats push and pop.
module fetch_fifo
   import cpu_pkg::*;
#(
   parameter int  DEPTH = 2,
   parameter type T     = fetch_entry_t,
   parameter int  CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  T              push_dat,
   input  logic          pop,
   input  logic          flush,
   output logic [CW-1:0] count,
   output T              head
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   T              r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_push;
   logic          w_pop;

   // Pointers wrap at DEPTH so non-power-of-two depths work.
   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign w_pop  = pop && (r_count != '0);
   assign w_push = push && ((r_count != CW'(DEPTH)) || w_pop);

   // Storage, pointers and occupancy; storage is cleared on reset so the head reads zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= push_dat;
            r_wr_ptr        <= ptr_next(r_wr_ptr);
         end
         if (w_pop) r_rd_ptr <= ptr_next(r_rd_ptr);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   assign count = r_count;
   assign head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/instruction_fetch.sv
// LEGv8 fetch stage: PC, single-outstanding IMem handshake, buffered {Address, Instruction} to decode.
// Latency: first instruction valid 3 cycles after reset release; data visible 1 cycle after IMemValid.
// Backpressure: Stall holds the head; no new request is issued while the buffer is full.
module instruction_fetch
   import cpu_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC   = 64'h0,
   parameter int                FIFO_DEPTH = 2
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic               PCSrc,
   input  logic [ADDR_W-1:0]  BranchAddress,
   input  logic               Stall,
   output logic               IMemReq,
   output logic [ADDR_W-1:0]  IMemAddr,
   input  logic               IMemReady,
   input  logic               IMemValid,
   input  logic [INSTR_W-1:0] IMemData,
   output logic               InstrValid,
   output logic [INSTR_W-1:0] Instruction,
   output logic [ADDR_W-1:0]  Address
);

   localparam int CW  = $clog2(FIFO_DEPTH + 1);
   localparam int CW1 = CW + 1;

   fetch_state_t      r_state;
   fetch_state_t      w_state_nxt;
   logic [ADDR_W-1:0] r_fetch_pc;
   logic [ADDR_W-1:0] w_fetch_pc_nxt;
   logic              r_squash;
   logic              w_squash_nxt;
   logic              r_imem_req;
   logic [ADDR_W-1:0] r_imem_addr;
   logic [CW-1:0]     w_count;
   logic [CW1-1:0]    w_count_after;
   logic              w_push;
   logic              w_pop;
   logic              w_has_room;
   logic              w_room_after;
   logic [ADDR_W-1:0] w_target;
   fetch_entry_t      w_push_dat;
   fetch_entry_t      w_head;

   assign w_target      = {BranchAddress[ADDR_W-1:2], 2'b00};
   // A redirect empties the buffer, so neither a pop nor a push counts that cycle.
   assign w_pop         = (w_count != '0) && !Stall && !PCSrc;
   assign w_push        = (r_state == WAIT) && IMemValid && !r_squash && !PCSrc;
   assign w_count_after = {1'b0, w_count} + CW1'(w_push) - CW1'(w_pop);
   assign w_has_room    = {1'b0, w_count} < CW1'(FIFO_DEPTH);
   assign w_room_after  = w_count_after < CW1'(FIFO_DEPTH);

   assign w_push_dat.addr  = r_fetch_pc;
   assign w_push_dat.instr = IMemData;

   // Next fetch PC, FSM state and squash flag; redirect dominates every other event.
   always_comb begin
      w_state_nxt    = r_state;
      w_squash_nxt   = r_squash;
      w_fetch_pc_nxt = r_fetch_pc;
      if (PCSrc)       w_fetch_pc_nxt = w_target;
      else if (w_push) w_fetch_pc_nxt = r_fetch_pc + PC_STEP;
      case (r_state)
         IDLE: begin
            if (PCSrc || w_has_room) w_state_nxt = REQ;
         end
         REQ: begin
            // A request accepted alongside a redirect fetches the old path; drop its reply.
            if (IMemReady) begin
               w_state_nxt  = WAIT;
               w_squash_nxt = PCSrc;
            end
         end
         WAIT: begin
            if (PCSrc) begin
               if (IMemValid) begin
                  w_state_nxt  = REQ;
                  w_squash_nxt = 1'b0;
               end else begin
                  w_squash_nxt = 1'b1;
               end
            end else if (IMemValid) begin
               w_squash_nxt = 1'b0;
               w_state_nxt  = w_room_after ? REQ : IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Registered state plus registered request outputs derived from next state.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_state     <= IDLE;
         r_fetch_pc  <= RESET_PC;
         r_squash    <= 1'b0;
         r_imem_req  <= 1'b0;
         r_imem_addr <= RESET_PC;
      end else begin
         r_state     <= w_state_nxt;
         r_fetch_pc  <= w_fetch_pc_nxt;
         r_squash    <= w_squash_nxt;
         r_imem_req  <= (w_state_nxt == REQ);
         r_imem_addr <= w_fetch_pc_nxt;
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .T     (fetch_entry_t)
   ) u_fifo (
      .clk      (Clock),
      .rst      (Reset),
      .push     (w_push),
      .push_dat (w_push_dat),
      .pop      (w_pop),
      .flush    (PCSrc),
      .count    (w_count),
      .head     (w_head)
   );

   assign IMemReq     = r_imem_req;
   assign IMemAddr    = r_imem_addr;
   assign InstrValid  = (w_count != '0);
   assign Instruction = w_head.instr;
   assign Address     = w_head.addr;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: two instances (normal and wrap-around reset PC) with memory models.
// Checks a cycle table, directed redirect/reset corners and a randomized run against a PC-stream model.
// The model: each delivered pair is the next sequential PC from the last reset or redirect target.
`timescale 1ns/1ps
module tb_instruction_fetch;

   logic Clock = 1'b0;
   always #5 Clock = ~Clock;

   logic        Reset;
   logic        PCSrc;
   logic        Stall;
   logic [63:0] BranchAddress;

   logic        req   [2];
   logic [63:0] maddr [2];
   logic        m_rdy [2];
   logic        m_vld [2];
   logic [31:0] m_dat [2];
   logic        ivld  [2];
   logic [31:0] instr [2];
   logic [63:0] adr   [2];

   instruction_fetch #(.RESET_PC(64'h100), .FIFO_DEPTH(2)) u_dut0 (
      .Clock(Clock), .Reset(Reset), .PCSrc(PCSrc), .BranchAddress(BranchAddress), .Stall(Stall),
      .IMemReq(req[0]), .IMemAddr(maddr[0]), .IMemReady(m_rdy[0]), .IMemValid(m_vld[0]),
      .IMemData(m_dat[0]), .InstrValid(ivld[0]), .Instruction(instr[0]), .Address(adr[0]));

   instruction_fetch #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFF8), .FIFO_DEPTH(2)) u_dut1 (
      .Clock(Clock), .Reset(Reset), .PCSrc(PCSrc), .BranchAddress(BranchAddress), .Stall(Stall),
      .IMemReq(req[1]), .IMemAddr(maddr[1]), .IMemReady(m_rdy[1]), .IMemValid(m_vld[1]),
      .IMemData(m_dat[1]), .InstrValid(ivld[1]), .Instruction(instr[1]), .Address(adr[1]));

   int n_chk;
   int n_fail;
   int n_pops;

   // Reference model state: reset PCs and next expected delivered address.
   logic [63:0] rpc    [2];
   logic [63:0] exp_pc [2];
   logic        p_ivld [2];
   logic [63:0] p_adr  [2];
   logic [31:0] p_instr[2];

   // Memory model state.
   bit          pend      [2];
   logic [63:0] pend_addr [2];
   int          lat       [2];
   int          mode_lat  [2];
   bit          seen_req  [2];
   logic [63:0] seen_addr [2];
   bit          rnd_rdy;

   typedef struct {
      logic        stall;
      logic        req;
      logic [63:0] addr;
      logic        ivld;
      logic [63:0] a;
      logic [31:0] ins;
      logic [63:0] a1;
   } vec_t;
   vec_t tbl [8];

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return 32'hAA00_0000 + a[31:0];
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: actual=%h required=%h at %0t", nm, act, expv, $time);
      end
   endtask

   task automatic mem_update(input int g);
      if (Reset) begin
         pend[g]     = 1'b0;
         m_vld[g]    = 1'b0;
         m_rdy[g]    = 1'b0;
         seen_req[g] = 1'b0;
      end else begin
         m_vld[g] = 1'b0;
         if (m_rdy[g] && seen_req[g]) begin
            pend[g]      = 1'b1;
            pend_addr[g] = seen_addr[g];
            lat[g]       = (mode_lat[g] < 0) ? int'($urandom_range(0, 3)) : mode_lat[g];
         end
         if (pend[g]) begin
            if (lat[g] == 0) begin
               m_vld[g] = 1'b1;
               m_dat[g] = mem_word(pend_addr[g]);
               pend[g]  = 1'b0;
            end else begin
               lat[g]--;
            end
         end
         m_rdy[g]     = pend[g] ? 1'b0 : (rnd_rdy ? 1'($urandom % 2) : 1'b1);
         seen_req[g]  = req[g];
         seen_addr[g] = maddr[g];
      end
   endtask

   // One clock: scoreboard the edge just taken, advance memories, capture outputs.
   task automatic tick();
      @(posedge Clock);
      #1;
      for (int g = 0; g < 2; g++) begin
         if (Reset) begin
            exp_pc[g] = rpc[g];
         end else if (PCSrc) begin
            exp_pc[g] = {BranchAddress[63:2], 2'b00};
            chk("redirect_ivld", 64'(ivld[g]), 64'd0);
         end else if (p_ivld[g] && !Stall) begin
            chk("pop_addr", p_adr[g], exp_pc[g]);
            chk("pop_instr", 64'(p_instr[g]), 64'(mem_word(exp_pc[g])));
            exp_pc[g] = exp_pc[g] + 64'd4;
            n_pops++;
         end
         mem_update(g);
         p_ivld[g]  = ivld[g];
         p_adr[g]   = adr[g];
         p_instr[g] = instr[g];
      end
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      PCSrc = 1'b0;
      Stall = 1'b0;
      repeat (3) tick();
      Reset = 1'b0;
   endtask

   initial begin
      bit found;
      int pops0;
      n_chk = 0; n_fail = 0; n_pops = 0;
      rpc[0] = 64'h100;
      rpc[1] = 64'hFFFF_FFFF_FFFF_FFF8;
      Reset = 1'b1; PCSrc = 1'b0; Stall = 1'b0; BranchAddress = '0;
      rnd_rdy = 1'b0;
      for (int g = 0; g < 2; g++) begin
         mode_lat[g] = 0; pend[g] = 1'b0; lat[g] = 0; m_rdy[g] = 1'b0; m_vld[g] = 1'b0;
         m_dat[g] = '0; seen_req[g] = 1'b0; seen_addr[g] = '0; exp_pc[g] = rpc[g];
         p_ivld[g] = 1'b0; p_adr[g] = '0; p_instr[g] = '0; pend_addr[g] = '0;
      end

      //                stall req addr        ivld Address     Instruction    wrap Address
      tbl[0] = '{1'b0, 1'b0, 64'h100, 1'b0, 64'h0,   32'h0,         64'h0};
      tbl[1] = '{1'b0, 1'b1, 64'h100, 1'b0, 64'h0,   32'h0,         64'h0};
      tbl[2] = '{1'b0, 1'b0, 64'h100, 1'b0, 64'h0,   32'h0,         64'h0};
      tbl[3] = '{1'b0, 1'b1, 64'h104, 1'b1, 64'h100, 32'hAA00_0100, 64'hFFFF_FFFF_FFFF_FFF8};
      tbl[4] = '{1'b0, 1'b0, 64'h104, 1'b0, 64'h0,   32'h0,         64'h0};
      tbl[5] = '{1'b0, 1'b1, 64'h108, 1'b1, 64'h104, 32'hAA00_0104, 64'hFFFF_FFFF_FFFF_FFFC};
      tbl[6] = '{1'b0, 1'b0, 64'h108, 1'b0, 64'h0,   32'h0,         64'h0};
      tbl[7] = '{1'b0, 1'b1, 64'h10C, 1'b1, 64'h108, 32'hAA00_0108, 64'h0};

      // Reset values.
      tick(); tick();
      for (int g = 0; g < 2; g++) begin
         chk("rst_req",   64'(req[g]),   64'd0);
         chk("rst_maddr", maddr[g],      rpc[g]);
         chk("rst_ivld",  64'(ivld[g]),  64'd0);
         chk("rst_instr", 64'(instr[g]), 64'd0);
         chk("rst_addr",  adr[g],        64'd0);
      end

      // Sequential fetch from reset, cycle by cycle; instance 1 wraps past 2^64.
      Reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         Stall = tbl[i].stall;
         chk("tbl_req",  64'(req[0]),  64'(tbl[i].req));
         chk("tbl_addr", maddr[0],     tbl[i].addr);
         chk("tbl_ivld", 64'(ivld[0]), 64'(tbl[i].ivld));
         if (tbl[i].ivld) begin
            chk("tbl_address", adr[0],           tbl[i].a);
            chk("tbl_instr",   64'(instr[0]),    64'(tbl[i].ins));
            chk("tbl_wrap",    adr[1],           tbl[i].a1);
            chk("tbl_wrap_iv", 64'(ivld[1]),     64'd1);
         end
         tick();
      end

      // Backpressure: buffer fills, requests stop, head holds.
      do_reset();
      Stall = 1'b1;
      for (int c = 0; c < 10; c++) begin
         if (c >= 5) chk("bp_req_full", 64'(req[0]), 64'd0);
         if (ivld[0]) chk("bp_head", adr[0], 64'h100);
         tick();
      end
      chk("bp_count", 64'(u_dut0.w_count), 64'd2);
      chk("bp_head_final", adr[0], 64'h100);
      pops0 = n_pops;
      Stall = 1'b0;
      repeat (20) tick();
      chk("bp_drain", 64'((n_pops - pops0) >= 10), 64'd1);

      // Redirect while the request to 0x10C is outstanding.
      do_reset();
      mode_lat[0] = 2;
      found = 1'b0;
      for (int c = 0; c < 60 && !found; c++) begin
         tick();
         if (pend[0] && pend_addr[0] == 64'h10C) found = 1'b1;
      end
      chk("rw_found", 64'(found), 64'd1);
      PCSrc = 1'b1; BranchAddress = 64'h2003;
      tick();
      PCSrc = 1'b0;
      chk("rw_ivld_after", 64'(ivld[0]), 64'd0);
      found = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
         if (req[0]) found = 1'b1; else tick();
      end
      chk("rw_req_seen", 64'(found), 64'd1);
      chk("rw_req_addr", maddr[0], 64'h2000);
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
         if (ivld[0]) found = 1'b1; else tick();
      end
      chk("rw_out_seen", 64'(found), 64'd1);
      chk("rw_out_addr", adr[0], 64'h2000);
      mode_lat[0] = 0;

      // Redirect in the same cycle the memory accepts a request.
      do_reset();
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
         if (req[0] && m_rdy[0]) found = 1'b1; else tick();
      end
      chk("rr_found", 64'(found), 64'd1);
      PCSrc = 1'b1; BranchAddress = 64'h3001;
      tick();
      PCSrc = 1'b0;
      chk("rr_ivld_after", 64'(ivld[0]), 64'd0);
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
         if (ivld[0]) found = 1'b1; else tick();
      end
      chk("rr_out_seen", 64'(found), 64'd1);
      chk("rr_out_addr", adr[0], 64'h3000);

      // Redirect coinciding with IMemValid and a would-be pop.
      Stall = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
         if (m_vld[0] && ivld[0]) found = 1'b1; else tick();
      end
      chk("rv_found", 64'(found), 64'd1);
      Stall = 1'b0; PCSrc = 1'b1; BranchAddress = 64'h4000;
      tick();
      PCSrc = 1'b0;
      chk("rv_ivld_after", 64'(ivld[0]), 64'd0);
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
         if (ivld[0]) found = 1'b1; else tick();
      end
      chk("rv_out_seen", 64'(found), 64'd1);
      chk("rv_out_addr", adr[0], 64'h4000);

      // Reset while waiting with one buffered entry.
      do_reset();
      mode_lat[0] = 3;
      Stall = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
         if (ivld[0] && pend[0]) found = 1'b1; else tick();
      end
      chk("rm_found", 64'(found), 64'd1);
      chk("rm_count", 64'(u_dut0.w_count), 64'd1);
      Reset = 1'b1;
      tick();
      chk("rm_ivld", 64'(ivld[0]), 64'd0);
      chk("rm_req",  64'(req[0]),  64'd0);
      Reset = 1'b0; Stall = 1'b0; mode_lat[0] = 0;
      found = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
         if (req[0]) found = 1'b1; else tick();
      end
      chk("rm_req_seen", 64'(found), 64'd1);
      chk("rm_req_addr", maddr[0], 64'h100);
      found = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
         if (ivld[0]) found = 1'b1; else tick();
      end
      chk("rm_out_seen", 64'(found), 64'd1);
      chk("rm_out_addr", adr[0], 64'h100);

      // Randomized run: random stall, memory timing, redirects and occasional reset.
      do_reset();
      mode_lat[0] = -1; mode_lat[1] = -1; rnd_rdy = 1'b1;
      pops0 = n_pops;
      for (int c = 0; c < 4000; c++) begin
         Stall = (($urandom % 4) == 0);
         PCSrc = (($urandom % 25) == 0);
         BranchAddress = (($urandom % 4) == 0) ? {32'hFFFF_FFFF, 32'($urandom)} : {32'h0, 32'($urandom)};
         Reset = (($urandom % 400) == 0);
         tick();
      end
      PCSrc = 1'b0; Reset = 1'b0; Stall = 1'b0;
      tick();
      chk("rnd_progress", 64'((n_pops - pops0) > 500), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Front-end stage of the LEGv8 CPU: holds the program counter, issues word reads to instruction memory over a request/acknowledge handshake, and buffers returned instructions in a small FIFO. It presents one `{Address, Instruction}` pair at a time to the instruction decode stage. It redirects on the `PCSrc`/`BranchAddress` pair produced downstream and squashes all in-flight and buffered wrong-path fetches.

## Interface
- `RESET_PC`, default 64'h0: fetch address after reset; bits [1:0] must be 0.
- `FIFO_DEPTH`, default 2: instruction buffer entries; must be ≥1.
- `Clock` in 1: single clock; all state updates on the rising edge.
- `Reset` in 1: synchronous, active-high.
- `PCSrc` in 1: branch-taken redirect from decode/execute.
- `BranchAddress` in 64: redirect target; bits [1:0] are ignored and treated as 0.
- `Stall` in 1: decode cannot accept this cycle.
- `IMemReq` out 1: read request valid.
- `IMemAddr` out 64: word address of the request.
- `IMemReady` in 1: memory accepts the request this cycle.
- `IMemValid` in 1: read data valid. Responses return in order, at most one outstanding.
- `IMemData` in 32: instruction word.
- `InstrValid` out 1: output pair valid.
- `Instruction` out 32: head-of-FIFO instruction.
- `Address` out 64: PC of `Instruction`.

## Operation
- State registers:
  - `FetchPC`: next address to request.
  - FSM with states `IDLE`, `REQ`, `WAIT`.
  - `Squash` flag.
  - FIFO of `{Address, Instruction}` with an occupancy count.
- Reset: `FetchPC`=RESET_PC, state `IDLE`, `Squash`=0, FIFO emptied.
- Reset values of outputs: `IMemReq`=0, `IMemAddr`=RESET_PC, `InstrValid`=0, `Instruction`=0, `Address`=0.
- `IDLE`: go to `REQ` when count < FIFO_DEPTH. Because only one request is ever outstanding, a push can never overflow the FIFO.
- `REQ`: drive `IMemReq`=1 and `IMemAddr`=`FetchPC`. Go to `WAIT` when `IMemReady`=1. `IMemAddr` is held stable until accepted, except on a redirect.
- `WAIT`: on `IMemValid`:
  - If `Squash`=0: push `{FetchPC, IMemData}` and set `FetchPC`+=4.
  - If `Squash`=1: discard the data and clear `Squash`.
  - Next state is `REQ` if count after push/pop < FIFO_DEPTH, else `IDLE`.
- Output: `InstrValid`=FIFO non-empty. Head is popped when `InstrValid` and `!Stall`. Push and pop may occur in the same cycle.
- `FetchPC` wraps modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFC + 4 = 0.
- Redirect (`PCSrc`=1) has priority over every other event in the same cycle:
  - FIFO is cleared and no pop is counted.
  - `FetchPC` ← {BranchAddress[63:2], 2'b00}.
  - In `REQ` with `IMemReady`=1 the same cycle: the accepted request is stale, so go to `WAIT` with `Squash`=1.
  - In `REQ` without ready: stay in `REQ`; the new address is driven next cycle.
  - In `WAIT` with no `IMemValid` this cycle: set `Squash`=1.
  - In `WAIT` with `IMemValid` this cycle: discard the data, `Squash` stays 0, go to `REQ`.
  - In `IDLE`: go to `REQ`.
- Reset asserted mid-transaction: all state returns to reset values. Memory must drop any outstanding response; no `IMemValid` arrives in the cycle after `Reset`.

## Timing
- Cycle 0 is the first cycle with `Reset`=0:
  - cycle 0: `IDLE`→`REQ`.
  - cycle 1: `IMemReq`=1, `IMemAddr`=RESET_PC.
- With zero-wait memory (ready same cycle, valid next cycle), data is pushed at the end of cycle 2 and `InstrValid`=1 in cycle 3.
- Steady-state throughput is one instruction per 2 cycles (`REQ`, `WAIT`).
- Fetch-to-output latency is 1 cycle after the `IMemValid` edge.
- Redirect: `InstrValid`=0 in the cycle after `PCSrc`. A request to the target is issued no later than:
  - the next cycle, if not outstanding;
  - the cycle after the pending response, if a request was outstanding.
- All outputs are registered except `InstrValid`/`Instruction`/`Address`, which are read directly from FIFO storage.

## Structure
- Shared package `cpu_pkg`:
  - `INSTR_W`=32, `ADDR_W`=64;
  - `PC_STEP`=4;
  - `fetch_state_t` enum {`IDLE`, `REQ`, `WAIT`};
  - `fetch_entry_t` struct {Address, Instruction}.
- Sub-module `fetch_fifo`:
  - parameterised by depth and entry type;
  - ports: push, pop, flush, count, head.
  - Flush has priority over push and pop.
- FSM, `FetchPC`, `Squash` and redirect logic live in `instruction_fetch`.

## Test plan
- Reset and sequential fetch: RESET_PC=0x100, zero-wait memory returning 0xAA000000+addr, `Stall`=0. Required: pairs (0x100,0xAA000100), (0x104,0xAA000104), (0x108,0xAA000108), first `InstrValid` in cycle 3, one pair per 2 cycles.
- Backpressure: hold `Stall`=1 for 10 cycles. Required: FIFO fills to 2, `IMemReq` stays 0 while full, head stays (0x100,…). Release `Stall`: order is preserved, no duplicates or losses.
- Redirect during `WAIT`: `PCSrc`=1, `BranchAddress`=0x2003 while a request to 0x10C is outstanding. Required: the 0x10C data is discarded, `IMemAddr`=0x2000 next, first output is (0x2000,…).
- Simultaneous redirect with `IMemReady` in `REQ`, plus `PCSrc` coinciding with `IMemValid` and pop. Required: no stale instruction ever appears with `InstrValid`=1; the next valid `Address`=target.
- Wrap-around: RESET_PC=0xFFFF_FFFF_FFFF_FFF8. Required: addresses …FFF8, …FFFC, 0x0.
- Reset mid-`WAIT` with FIFO holding 1 entry. Required: the next cycle has `InstrValid`=0, `IMemReq`=0, and fetch restarts at RESET_PC.
